// File: rtl/multiplier_unsigned_pipelined.sv
// 32x32 -> 64 unsigned multiplier built as an 8-stage radix-2 shift-add pipeline.
// Each stage retires four multiplier bits; a global stall freezes the whole pipe.
module multiplier_unsigned_pipelined (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        i_valid,
  input  logic [31:0] i_multiplicand,
  input  logic [31:0] i_multiplier,
  output logic [31:0] o_product_hi,
  output logic [31:0] o_product_lo,
  output logic        o_valid
);

  localparam int unsigned NUM_STAGES = 8;

  // Four serial shift-add steps for one stage; bits[j] weights the multiplicand by 2^(4*stage+j).
  function automatic logic [63:0] shift_add4(
    input logic [63:0] acc,
    input logic [31:0] mcand,
    input logic [3:0]  bits,
    input logic [2:0]  stage
  );
    logic [63:0] sum;
    logic [5:0]  shamt;
    sum   = acc;
    shamt = 6'd0;
    for (int j = 0; j < 4; j++) begin
      shamt = {1'b0, stage, 2'b00} + 6'(j);
      if (bits[j]) begin
        sum = sum + ({32'd0, mcand} << shamt);
      end else begin
        sum = sum;
      end
    end
    return sum;
  endfunction

  // Stage registers; the final stage only needs the accumulator and valid.
  logic [63:0] acc_r   [1:NUM_STAGES];
  logic [31:0] mcand_r [1:NUM_STAGES-1];
  logic [31:0] rem_r   [1:NUM_STAGES-1];
  logic [NUM_STAGES:1] valid_r;

  // Per-stage combinational view: stage 0 comes straight from the inputs.
  logic [63:0] acc_in_s   [0:NUM_STAGES-1];
  logic [31:0] mcand_in_s [0:NUM_STAGES-1];
  logic [31:0] rem_in_s   [0:NUM_STAGES-1];
  logic [NUM_STAGES-1:0] valid_in_s;
  logic [63:0] acc_nxt_s  [0:NUM_STAGES-1];

  // Select each stage's operands: inputs for stage 0, registers beyond.
  always_comb begin
    acc_in_s[0]   = 64'd0;
    mcand_in_s[0] = i_multiplicand;
    rem_in_s[0]   = i_multiplier;
    valid_in_s[0] = i_valid;
    for (int k = 1; k < NUM_STAGES; k++) begin
      acc_in_s[k]   = acc_r[k];
      mcand_in_s[k] = mcand_r[k];
      rem_in_s[k]   = rem_r[k];
      valid_in_s[k] = valid_r[k];
    end
  end

  // Partial-product accumulation for every stage.
  always_comb begin
    for (int k = 0; k < NUM_STAGES; k++) begin
      acc_nxt_s[k] = shift_add4(acc_in_s[k], mcand_in_s[k], rem_in_s[k][3:0], 3'(k));
    end
  end

  // Pipeline advance: async clear, freeze on stall, otherwise shift one stage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 1; k <= NUM_STAGES; k++) begin
        acc_r[k] <= 64'd0;
      end
      for (int k = 1; k < NUM_STAGES; k++) begin
        mcand_r[k] <= 32'd0;
        rem_r[k]   <= 32'd0;
      end
      valid_r <= '0;
    end else if (!stall) begin
      for (int k = 1; k < NUM_STAGES; k++) begin
        acc_r[k]   <= acc_nxt_s[k-1];
        mcand_r[k] <= mcand_in_s[k-1];
        rem_r[k]   <= rem_in_s[k-1] >> 4;
        valid_r[k] <= valid_in_s[k-1];
      end
      acc_r[NUM_STAGES]   <= acc_nxt_s[NUM_STAGES-1];
      valid_r[NUM_STAGES] <= valid_in_s[NUM_STAGES-1];
    end else begin
      valid_r <= valid_r;
    end
  end

  assign o_product_hi = acc_r[NUM_STAGES][63:32];
  assign o_product_lo = acc_r[NUM_STAGES][31:0];
  assign o_valid      = valid_r[NUM_STAGES];

endmodule
